// File: rtl/mem_bus_master.sv
// mem_bus_master
// Initiator end of the 8-bit bidirectional byte-bus memory protocol. A host
// burst request becomes a bus sequence on data_io:
//   - a mode byte: 8'hFF for a write burst, 8'h00 for a read burst;
//   - then one data byte per write beat, or, per read beat, a poll byte,
//     TURN_CYCLES idle cycles and one sample cycle.
// Write bytes 8'h00 and 8'hFF are reserved. They are sent as 8'h01 and
// 8'hFE, and err_o pulses for each one substituted.
//
// Ports:
//   clk_i, rst_i          clock; synchronous active-high reset
//   data_io               shared byte bus, driven only while tx_oe=1
//   tx_oe                 bus drive enable
//   cmd_valid_i/ready_o   host burst request handshake (ready only in IDLE)
//   cmd_write_i, cmd_len_i  burst direction and beat count (0 = mode byte only)
//   wr_data_i/valid_i/ready_o  write beat stream
//   rd_data_o, rd_valid_o captured read byte and its one-cycle strobe
//   busy_o, done_o, err_o status: not idle / burst end / byte substituted
//
// Optional build macro MEM_BUS_CSUM_EN adds csum_o[7:0]: the XOR of every
// data byte sent (after substitution) or received in the current burst. It is
// cleared when a command is accepted and is valid while done_o is high.
module mem_bus_master #(
  parameter int          LEN_W       = 8,
  parameter logic [7:0]  POLL_BYTE   = 8'h55,
  parameter int          TURN_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  inout  wire  [7:0]       data_io,
  output logic             tx_oe,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [7:0]       wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
`ifdef MEM_BUS_CSUM_EN
  ,
  output logic [7:0]       csum_o
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MODE    = 3'd1,
    WBEAT   = 3'd2,
    RPOLL   = 3'd3,
    RTURN   = 3'd4,
    RSAMPLE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_write;
  logic [LEN_W-1:0] r_cnt;
  logic [2:0]       r_turn;
  logic [7:0]       w_tx_byte;
  logic [7:0]       w_wr_sub;
  logic             w_wr_rsvd;
  logic             w_wr_fire;

  assign data_io     = tx_oe ? w_tx_byte : 8'hzz;
  assign cmd_ready_o = (r_state == IDLE);
  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == DONE);

  // Reserved write values are nudged by one toward the middle of the range.
  always_comb begin
    w_wr_rsvd = 1'b0;
    w_wr_sub  = wr_data_i;
    if (wr_data_i == 8'h00) begin
      w_wr_rsvd = 1'b1;
      w_wr_sub  = 8'h01;
    end else if (wr_data_i == 8'hFF) begin
      w_wr_rsvd = 1'b1;
      w_wr_sub  = 8'hFE;
    end else begin
      w_wr_rsvd = 1'b0;
      w_wr_sub  = wr_data_i;
    end
  end

  // Next-state and bus/handshake decode.
  always_comb begin
    w_next     = r_state;
    tx_oe      = 1'b0;
    w_tx_byte  = 8'h00;
    wr_ready_o = 1'b0;
    err_o      = 1'b0;
    w_wr_fire  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid_i) w_next = MODE;
      end
      MODE: begin
        tx_oe     = 1'b1;
        w_tx_byte = r_write ? 8'hFF : 8'h00;
        if (r_cnt == '0)  w_next = DONE;
        else if (r_write) w_next = WBEAT;
        else              w_next = RPOLL;
      end
      WBEAT: begin
        wr_ready_o = 1'b1;
        // The bus stays released until a beat is actually offered.
        if (wr_valid_i) begin
          w_wr_fire = 1'b1;
          tx_oe     = 1'b1;
          w_tx_byte = w_wr_sub;
          err_o     = w_wr_rsvd;
          if (r_cnt == LEN_W'(1)) w_next = DONE;
        end
      end
      RPOLL: begin
        tx_oe     = 1'b1;
        w_tx_byte = POLL_BYTE;
        w_next    = RTURN;
      end
      RTURN: begin
        if (r_turn == 3'(TURN_CYCLES - 1)) w_next = RSAMPLE;
      end
      RSAMPLE: begin
        if (r_cnt == LEN_W'(1)) w_next = DONE;
        else                    w_next = RPOLL;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State, beat/turn counters and read capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_cnt      <= '0;
      r_turn     <= 3'd0;
      rd_data_o  <= 8'h00;
      rd_valid_o <= 1'b0;
    end else begin
      r_state    <= w_next;
      rd_valid_o <= (r_state == RSAMPLE);
      if (r_state == IDLE && cmd_valid_i) begin
        r_write <= cmd_write_i;
        r_cnt   <= cmd_len_i;
      end
      if (w_wr_fire) r_cnt <= r_cnt - LEN_W'(1);
      if (r_state == RSAMPLE) begin
        rd_data_o <= data_io;
        r_cnt     <= r_cnt - LEN_W'(1);
      end
      // Turn counter restarts on every poll so each beat gets a full turnaround.
      if (r_state == RPOLL)      r_turn <= 3'd0;
      else if (r_state == RTURN) r_turn <= r_turn + 3'd1;
    end
  end

`ifdef MEM_BUS_CSUM_EN
  // Running XOR of data bytes only; mode and poll bytes never contribute.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csum_o <= 8'h00;
    end else if (r_state == IDLE && cmd_valid_i) begin
      csum_o <= 8'h00;
    end else if (w_wr_fire) begin
      csum_o <= csum_o ^ w_wr_sub;
    end else if (r_state == RSAMPLE) begin
      csum_o <= csum_o ^ data_io;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;

  logic       clk_i = 1'b0;
  logic       rst_i;
  wire  [7:0] data_io;
  logic       tx_oe;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic       cmd_write_i;
  logic [7:0] cmd_len_i;
  logic [7:0] wr_data_i;
  logic       wr_valid_i;
  logic       wr_ready_o;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
`ifdef MEM_BUS_CSUM_EN
  logic [7:0] csum_o;
`endif

  // Responder side of the bus: drives a byte only while the master is released.
  logic       tb_en;
  logic [7:0] tb_byte;
  assign data_io = (tb_en && !tx_oe) ? tb_byte : 8'hzz;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_i = ~clk_i;

  mem_bus_master dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_io     (data_io),
    .tx_oe       (tx_oe),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_write_i (cmd_write_i),
    .cmd_len_i   (cmd_len_i),
    .wr_data_i   (wr_data_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
`ifdef MEM_BUS_CSUM_EN
    ,
    .csum_o      (csum_o)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Accept a command in IDLE and check the mode byte in the following cycle.
  task automatic issue(input logic w, input logic [7:0] len);
    chk("idle_ready", {7'd0, cmd_ready_o}, 8'd1);
    cmd_valid_i = 1'b1;
    cmd_write_i = w;
    cmd_len_i   = len;
    cyc();
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_len_i   = 8'd0;
    #1;
    chk("mode_oe", {7'd0, tx_oe}, 8'd1);
    chk("mode_byte", data_io, w ? 8'hFF : 8'h00);
    chk("mode_busy", {7'd0, busy_o}, 8'd1);
  endtask

  task automatic wbeat(input logic [7:0] d, input logic [7:0] exp_bus, input logic exp_err);
    cyc();
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    #1;
    chk("wbeat_ready", {7'd0, wr_ready_o}, 8'd1);
    chk("wbeat_oe", {7'd0, tx_oe}, 8'd1);
    chk("wbeat_byte", data_io, exp_bus);
    chk("wbeat_err", {7'd0, err_o}, {7'd0, exp_err});
  endtask

  task automatic wgap();
    cyc();
    wr_valid_i = 1'b0;
    #1;
    chk("gap_ready", {7'd0, wr_ready_o}, 8'd1);
    chk("gap_oe", {7'd0, tx_oe}, 8'd0);
    chk("gap_done", {7'd0, done_o}, 8'd0);
  endtask

  // One read beat: poll, single turnaround cycle, sample with responder byte.
  task automatic rbeat(input logic [7:0] rd, input logic prev_v, input logic [7:0] prev_d);
    cyc();
    chk("rpoll_oe", {7'd0, tx_oe}, 8'd1);
    chk("rpoll_byte", data_io, 8'h55);
    chk("rpoll_rdv", {7'd0, rd_valid_o}, {7'd0, prev_v});
    if (prev_v) chk("rpoll_rdd", rd_data_o, prev_d);
    cyc();
    chk("rturn_oe", {7'd0, tx_oe}, 8'd0);
    tb_en   = 1'b1;
    tb_byte = rd;
    cyc();
    chk("rsample_oe", {7'd0, tx_oe}, 8'd0);
    chk("rsample_rdv", {7'd0, rd_valid_o}, 8'd0);
  endtask

  task automatic expect_done(input logic [7:0] csum_exp);
    cyc();
    wr_valid_i = 1'b0;
    tb_en      = 1'b0;
    #1;
    chk("done_pulse", {7'd0, done_o}, 8'd1);
    chk("done_oe", {7'd0, tx_oe}, 8'd0);
    chk("done_err", {7'd0, err_o}, 8'd0);
`ifdef MEM_BUS_CSUM_EN
    chk("csum", csum_o, csum_exp);
`else
    if (csum_exp != 8'h00) begin
    end
`endif
    cyc();
    chk("post_done", {7'd0, done_o}, 8'd0);
    chk("post_ready", {7'd0, cmd_ready_o}, 8'd1);
    chk("post_busy", {7'd0, busy_o}, 8'd0);
  endtask

  initial begin
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_len_i   = 8'd0;
    wr_data_i   = 8'h00;
    wr_valid_i  = 1'b0;
    tb_en       = 1'b0;
    tb_byte     = 8'h00;

    // Reset state
    cyc();
    cyc();
    chk("rst_oe", {7'd0, tx_oe}, 8'd0);
    chk("rst_ready", {7'd0, cmd_ready_o}, 8'd1);
    chk("rst_wready", {7'd0, wr_ready_o}, 8'd0);
    chk("rst_rdd", rd_data_o, 8'h00);
    chk("rst_rdv", {7'd0, rd_valid_o}, 8'd0);
    chk("rst_busy", {7'd0, busy_o}, 8'd0);
    chk("rst_done", {7'd0, done_o}, 8'd0);
    chk("rst_err", {7'd0, err_o}, 8'd0);
    rst_i = 1'b0;
    cyc();

    // Write burst of three plain bytes
    issue(1'b1, 8'd3);
    wbeat(8'h11, 8'h11, 1'b0);
    wbeat(8'h22, 8'h22, 1'b0);
    wbeat(8'h33, 8'h33, 1'b0);
    expect_done(8'h00);

    // Read burst of two beats
    issue(1'b0, 8'd2);
    rbeat(8'hA5, 1'b0, 8'h00);
    rbeat(8'h5A, 1'b1, 8'hA5);
    cyc();
    tb_en = 1'b0;
    chk("rd_done", {7'd0, done_o}, 8'd1);
    chk("rd_last_v", {7'd0, rd_valid_o}, 8'd1);
    chk("rd_last_d", rd_data_o, 8'h5A);
`ifdef MEM_BUS_CSUM_EN
    chk("rd_csum", csum_o, 8'hFF);
`endif
    cyc();
    chk("rd_post_v", {7'd0, rd_valid_o}, 8'd0);
    chk("rd_post_ready", {7'd0, cmd_ready_o}, 8'd1);

    // Reserved write bytes are substituted
    issue(1'b1, 8'd2);
    wbeat(8'h00, 8'h01, 1'b1);
    wbeat(8'hFF, 8'hFE, 1'b1);
    expect_done(8'hFF);

    // Zero-length write and read
    issue(1'b1, 8'd0);
    expect_done(8'h00);
    issue(1'b0, 8'd0);
    expect_done(8'h00);

    // Gapped write burst of four
    issue(1'b1, 8'd4);
    wgap();
    wbeat(8'hA1, 8'hA1, 1'b0);
    wgap();
    wgap();
    wbeat(8'hB2, 8'hB2, 1'b0);
    wgap();
    wgap();
    wbeat(8'hC3, 8'hC3, 1'b0);
    wgap();
    wgap();
    wbeat(8'hD4, 8'hD4, 1'b0);
    expect_done(8'h04);

    // Reset during turnaround aborts the read
    issue(1'b0, 8'd3);
    cyc();
    chk("ab_poll_oe", {7'd0, tx_oe}, 8'd1);
    cyc();
    chk("ab_turn_oe", {7'd0, tx_oe}, 8'd0);
    rst_i   = 1'b1;
    tb_en   = 1'b1;
    tb_byte = 8'h3C;
    cyc();
    rst_i = 1'b0;
    tb_en = 1'b0;
    chk("ab_oe", {7'd0, tx_oe}, 8'd0);
    chk("ab_ready", {7'd0, cmd_ready_o}, 8'd1);
    chk("ab_busy", {7'd0, busy_o}, 8'd0);
    chk("ab_rdv", {7'd0, rd_valid_o}, 8'd0);
    chk("ab_done", {7'd0, done_o}, 8'd0);
    cyc();
    chk("ab_rdv2", {7'd0, rd_valid_o}, 8'd0);
    chk("ab_done2", {7'd0, done_o}, 8'd0);

    // Recovery after abort
    issue(1'b1, 8'd1);
    wbeat(8'h5A, 8'h5A, 1'b0);
    expect_done(8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
